// File: rtl/pc_stack_unit.sv
// ============================================================================
//  Module   : pc_stack_unit
//  Brief    : Program counter with next-PC select, return-address stack and
//             exception vectoring for the fetch path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_stack_unit #(
   parameter int             N         = 9,
   parameter int             INC       = 1,
   parameter int             DEPTH     = 4,
   parameter logic [N-1:0]   RESET_VEC = {N{1'b1}},
   parameter logic [N-1:0]   EXC_VEC   = '0
) (
   input  logic                         btn,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         br_take,
   input  logic [N-1:0]                 br_off,
   input  logic                         jmp,
   input  logic                         call,
   input  logic                         ret,
   input  logic [N-1:0]                 jmp_addr,
   input  logic                         exc,
   output logic [N-1:0]                 o_pc,
   output logic [N-1:0]                 o_epc,
   output logic [$clog2(DEPTH+1)-1:0]   o_depth,
   output logic                         o_empty,
   output logic                         o_ovf,
   output logic                         o_unf
);

   localparam int           c_dw  = $clog2(DEPTH + 1);
   localparam int           c_pw  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [N-1:0] c_inc = N'(INC);

   logic [N-1:0]    pc_q, pc_d;
   logic [N-1:0]    epc_q, epc_d;
   logic [c_dw-1:0] depth_q, depth_d;
   logic [c_pw-1:0] top_q, top_d;
   logic            ovf_q, ovf_d;
   logic            unf_q, unf_d;
   logic [N-1:0]    stack_q [DEPTH];

   logic [N-1:0]    pc_inc;
   logic [c_pw-1:0] top_inc;
   logic [c_pw-1:0] top_dec;
   logic            push;

   // top_q is the next free slot; when full it also holds the oldest entry,
   // so a push at full naturally overwrites the oldest return address.
   assign pc_inc  = pc_q + c_inc;
   assign top_inc = (top_q == c_pw'(DEPTH - 1)) ? '0 : top_q + c_pw'(1);
   assign top_dec = (top_q == '0) ? c_pw'(DEPTH - 1) : top_q - c_pw'(1);

   always_comb begin
      pc_d    = pc_q;
      epc_d   = epc_q;
      depth_d = depth_q;
      top_d   = top_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push    = 1'b0;
      if (en) begin
         if (exc) begin
            epc_d = pc_q;
            pc_d  = EXC_VEC;
         end else if (ret) begin
            if (depth_q != '0) begin
               pc_d    = stack_q[top_dec];
               top_d   = top_dec;
               depth_d = depth_q - c_dw'(1);
            end else begin
               unf_d = 1'b1;
               pc_d  = pc_inc;
            end
         end else if (call) begin
            push  = 1'b1;
            pc_d  = jmp_addr;
            top_d = top_inc;
            if (depth_q == c_dw'(DEPTH)) begin
               ovf_d = 1'b1;
            end else begin
               depth_d = depth_q + c_dw'(1);
            end
         end else if (jmp) begin
            pc_d = jmp_addr;
         end else if (br_take) begin
            pc_d = pc_q + br_off;
         end else begin
            pc_d = pc_inc;
         end
      end
   end

   always_ff @(posedge btn) begin
      if (!rst) begin
         pc_q    <= RESET_VEC;
         epc_q   <= '0;
         depth_q <= '0;
         top_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         depth_q <= depth_d;
         top_q   <= top_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         if (push) begin
            stack_q[top_q] <= pc_inc;
         end
      end
   end

   assign o_pc    = pc_q;
   assign o_epc   = epc_q;
   assign o_depth = depth_q;
   assign o_empty = (depth_q == '0);
   assign o_ovf   = ovf_q;
   assign o_unf   = unf_q;

endmodule

`default_nettype wire
